// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes, FSM states
// and the per-size byte lane masks.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACC_LO = 2'd1;
    localparam logic [1:0] ST_ACC_HI = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    function automatic logic funct3_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Size is carried in funct3[1:0]; the sign/zero choice does not affect lanes.
    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = MASK_B;
            2'b01:   m = MASK_H;
            2'b10:   m = MASK_W;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load result formatter: aligns the two-word read buffer by byte offset and
// applies sign or zero extension for the access size.
module lsu_load_extend
    import load_store_unit_pkg::*;
(
    input  logic [63:0] line_buf,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] word_s;

    assign word_s = 32'(line_buf >> {off, 3'b000});

    // Extension by access size and signedness.
    always_comb begin
        data = 32'h0000_0000;
        case (funct3)
            F3_B:    data = {{24{word_s[7]}}, word_s[7:0]};
            F3_BU:   data = {24'h00_0000, word_s[7:0]};
            F3_H:    data = {{16{word_s[15]}}, word_s[15:0]};
            F3_HU:   data = {16'h0000, word_s[15:0]};
            F3_W:    data = word_s;
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-addressed, byte-enabled memory; misaligned
// accesses are split into two word accesses when they cross a word boundary.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] load_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_byte_en,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(3'd4);

    logic [1:0]          state_r, state_next_s;
    logic                is_store_r;
    logic [2:0]          funct3_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [2*DATA_W-1:0] buf_r, buf_next_s;
    logic                ready_r, resp_valid_r, resp_err_r;
    logic [DATA_W-1:0]   load_data_r;

    logic                accept_s;
    logic [1:0]          off_s;
    logic [7:0]          lane_s;
    logic [2*DATA_W-1:0] store_s;
    logic [ADDR_W-1:0]   word_addr_s;
    logic [DATA_W-1:0]   ext_s;

    assign accept_s    = (state_r == ST_IDLE) && ready_r && req_valid;
    assign off_s       = addr_r[1:0];
    assign lane_s      = {4'b0000, size_mask(funct3_r)} << off_s;
    assign store_s     = {{DATA_W{1'b0}}, wdata_r} << {off_s, 3'b000};
    assign word_addr_s = {addr_r[ADDR_W-1:2], 2'b00};

    // Next state and read-buffer update; ext_s sees the buffer as it will be in RESP.
    always_comb begin
        state_next_s = state_r;
        buf_next_s   = buf_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = funct3_legal(req_funct3) ? ST_ACC_LO : ST_RESP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACC_LO: begin
                buf_next_s   = {{DATA_W{1'b0}}, mem_rdata};
                state_next_s = (lane_s[7:4] != 4'b0000) ? ST_ACC_HI : ST_RESP;
            end
            ST_ACC_HI: begin
                buf_next_s   = {mem_rdata, buf_r[DATA_W-1:0]};
                state_next_s = ST_RESP;
            end
            ST_RESP:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    lsu_load_extend u_load_extend (
        .line_buf (buf_next_s),
        .off      (off_s),
        .funct3   (funct3_r),
        .data     (ext_s)
    );

    // State, request capture and read buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            is_store_r <= 1'b0;
            funct3_r   <= 3'b000;
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            buf_r      <= {(2*DATA_W){1'b0}};
        end else begin
            state_r <= state_next_s;
            buf_r   <= buf_next_s;
            if (accept_s) begin
                is_store_r <= req_is_store;
                funct3_r   <= req_funct3;
                addr_r     <= req_addr;
                wdata_r    <= req_wdata;
            end else begin
                is_store_r <= is_store_r;
            end
        end
    end

    // Handshake and response outputs; err/data hold between responses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_r      <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            load_data_r  <= {DATA_W{1'b0}};
        end else begin
            ready_r      <= (state_next_s == ST_IDLE);
            resp_valid_r <= (state_next_s == ST_RESP);
            if (state_next_s == ST_RESP) begin
                resp_err_r  <= (state_r == ST_IDLE);
                load_data_r <= ((state_r == ST_IDLE) || is_store_r) ? {DATA_W{1'b0}} : ext_s;
            end else begin
                resp_err_r  <= resp_err_r;
            end
        end
    end

    // Memory port decode from registered state and request fields only.
    always_comb begin
        mem_we      = 1'b0;
        mem_addr    = {ADDR_W{1'b0}};
        mem_wdata   = {DATA_W{1'b0}};
        mem_byte_en = 4'b0000;
        case (state_r)
            ST_ACC_LO: begin
                mem_we      = is_store_r;
                mem_addr    = word_addr_s;
                mem_wdata   = store_s[DATA_W-1:0];
                mem_byte_en = lane_s[3:0];
            end
            ST_ACC_HI: begin
                mem_we      = is_store_r;
                mem_addr    = word_addr_s + WORD_STEP;
                mem_wdata   = store_s[2*DATA_W-1:DATA_W];
                mem_byte_en = lane_s[7:4];
            end
            default: begin
                mem_we      = 1'b0;
                mem_byte_en = 4'b0000;
            end
        endcase
    end

    assign req_ready  = ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign load_data  = load_data_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a byte-level
// reference memory and per-cycle expectation queue.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid, resp_err;
    logic [31:0] load_data;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_byte_en;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rv;
        logic        err;
        logic [31:0] ld;
    } exp_t;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    exp_t        exp_q[$];
    acc_t        obs_q[$];
    logic [31:0] dut_mem [0:255];
    logic [31:0] ref_mem [0:255];
    int          errors = 0;
    int          checks = 0;
    bit          chk_en = 1'b0;
    logic [31:0] last_ld = 32'h0;
    logic        last_err = 1'b0;
    logic        pre_en = 1'b0;
    logic [7:0]  pre_idx = 8'h0;
    logic [31:0] pre_val = 32'h0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .load_data    (load_data),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_byte_en  (mem_byte_en),
        .mem_rdata    (mem_rdata)
    );

    // 1 KB environment memory: combinational read, byte-enabled posedge write.
    assign mem_rdata = dut_mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (pre_en) dut_mem[pre_idx] <= pre_val;
        else if (mem_we)
            for (int i = 0; i < 4; i++)
                if (mem_byte_en[i]) dut_mem[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        pre_idx = 8'(idx);
        pre_val = v;
        pre_en  = 1'b1;
        @(posedge clk); #1;
        pre_en  = 1'b0;
        ref_mem[idx] = v;
    endtask

    // Reference: byte-by-byte access semantics; pushes one record per cycle after accept.
    task automatic model_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input bit push, input bit lo_only,
                             output logic [31:0] val, output int lat);
        int size;
        bit sgn;
        logic [31:0] w0, w1, b, d0, d1;
        logic [3:0]  be0, be1;
        size = 0; sgn = 1'b0;
        case (f3)
            3'b000: begin size = 1; sgn = 1'b1; end
            3'b001: begin size = 2; sgn = 1'b1; end
            3'b010: size = 4;
            3'b100: size = 1;
            3'b101: size = 2;
            default: size = 0;
        endcase
        val = 32'h0; be0 = 4'h0; be1 = 4'h0; d0 = 32'h0; d1 = 32'h0;
        w0 = {a[31:2], 2'b00};
        w1 = w0 + 32'd4;
        if (size == 0) begin
            lat = 1;
            if (push) exp_q.push_back('{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0});
            return;
        end
        for (int i = 0; i < size; i++) begin
            b = a + 32'(i);
            if (b[31:2] == w0[31:2]) begin
                be0[b[1:0]] = 1'b1;
                d0[8*int'(b[1:0]) +: 8] = wd[8*i +: 8];
            end else begin
                be1[b[1:0]] = 1'b1;
                d1[8*int'(b[1:0]) +: 8] = wd[8*i +: 8];
            end
            if (st) begin
                if (!lo_only || b[31:2] == w0[31:2])
                    ref_mem[b[9:2]][8*int'(b[1:0]) +: 8] = wd[8*i +: 8];
            end else begin
                val[8*i +: 8] = ref_mem[b[9:2]][8*int'(b[1:0]) +: 8];
            end
        end
        if (sgn && size == 1) val = {{24{val[7]}}, val[7:0]};
        if (sgn && size == 2) val = {{16{val[15]}}, val[15:0]};
        lat = (be1 != 4'h0) ? 3 : 2;
        if (push) begin
            exp_q.push_back('{st, be0, w0, d0, 1'b0, 1'b0, 32'h0});
            if (be1 != 4'h0) exp_q.push_back('{st, be1, w1, d1, 1'b0, 1'b0, 32'h0});
            exp_q.push_back('{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, st ? 32'h0 : val});
        end
    endtask

    // Per-cycle comparison against the queued expectations (idle when empty).
    task automatic cmp_cycle();
        exp_t e;
        logic [31:0] m;
        if (!reset) begin
            last_ld  = 32'h0;
            last_err = 1'b0;
            exp_q.delete();
        end else if (chk_en) begin
            if (mem_we || mem_byte_en != 4'h0)
                obs_q.push_back('{mem_we, mem_byte_en, mem_addr, mem_wdata});
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("req_ready_busy", 32'(req_ready), 32'h0);
            end else begin
                e = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
                check("req_ready_idle", 32'(req_ready), 32'h1);
            end
            check("mem_we", 32'(mem_we), 32'(e.we));
            check("mem_byte_en", 32'(mem_byte_en), 32'(e.be));
            if (e.be != 4'h0) begin
                check("mem_addr", mem_addr, e.addr);
                for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{e.be[i]}};
                check("mem_wdata", mem_wdata & m, e.wdata);
            end
            check("resp_valid", 32'(resp_valid), 32'(e.rv));
            if (e.rv) begin
                last_err = e.err;
                last_ld  = e.ld;
            end
            check("resp_err", 32'(resp_err), 32'(last_err));
            check("load_data", load_data, last_ld);
        end
    endtask

    always @(negedge clk) cmp_cycle();

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] mv);
        int lat;
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) check("ready_timeout", 32'(req_ready), 32'h1);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        // Junk on the request bus while busy must be ignored.
        req_valid    = 1'($urandom_range(0, 1));
        req_is_store = 1'($urandom_range(0, 1));
        req_funct3   = 3'($urandom_range(0, 7));
        req_addr     = $urandom;
        req_wdata    = $urandom;
        model_req(st, f3, a, wd, 1'b1, 1'b0, mv, lat);
        repeat (lat) @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] mv, a, w0_before;
        logic [2:0]  f3;
        logic [2:0]  f3_tab [5];
        int          lat;
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        #2;
        for (int i = 0; i < 256; i++) preload(i, $urandom);
        preload(0, 32'hDEADBEEF);
        preload(64, 32'hCAFEBABE);
        preload(65, 32'h00000099);

        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_byte_en", 32'(mem_byte_en), 32'h0);
        check("rst_load_data", load_data, 32'h0);
        @(negedge clk); reset = 1'b1; #1;
        check("rel_ready_before_edge", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        check("rel_ready_after_edge", 32'(req_ready), 32'h1);
        chk_en = 1'b1;

        obs_q.delete();
        do_req(1'b0, 3'b010, 32'h100, 32'h0, mv);
        check("lw100_model", mv, 32'hCAFEBABE);
        check("lw100_dut", load_data, 32'hCAFEBABE);
        check("lw100_err", 32'(resp_err), 32'h0);
        check("lw100_nacc", obs_q.size(), 32'd1);
        if (obs_q.size() >= 1) check("lw100_be", 32'(obs_q[0].be), 32'hF);

        do_req(1'b0, 3'b000, 32'h103, 32'h0, mv);
        check("lb103_model", mv, 32'hFFFFFFCA);
        check("lb103_dut", load_data, 32'hFFFFFFCA);
        do_req(1'b0, 3'b100, 32'h103, 32'h0, mv);
        check("lbu103_dut", load_data, 32'h000000CA);
        do_req(1'b0, 3'b101, 32'h002, 32'h0, mv);
        check("lhu002_model", mv, 32'h0000DEAD);
        check("lhu002_dut", load_data, 32'h0000DEAD);

        obs_q.delete();
        do_req(1'b0, 3'b001, 32'h103, 32'h0, mv);
        check("lh103_dut", load_data, 32'hFFFF99CA);
        check("lh103_nacc", obs_q.size(), 32'd2);
        if (obs_q.size() >= 2) begin
            check("lh103_addr0", obs_q[0].addr, 32'h100);
            check("lh103_be0", 32'(obs_q[0].be), 32'h8);
            check("lh103_addr1", obs_q[1].addr, 32'h104);
            check("lh103_be1", 32'(obs_q[1].be), 32'h1);
        end

        obs_q.delete();
        do_req(1'b1, 3'b010, 32'h102, 32'h11223344, mv);
        if (obs_q.size() >= 2) begin
            check("sw102_be0", 32'(obs_q[0].be), 32'hC);
            check("sw102_wd0", obs_q[0].wdata, 32'h33440000);
            check("sw102_be1", 32'(obs_q[1].be), 32'h3);
            check("sw102_wd1", obs_q[1].wdata, 32'h00001122);
        end else check("sw102_nacc", obs_q.size(), 32'd2);
        check("sw102_mem100", dut_mem[64], 32'h3344BABE);
        check("sw102_mem104", dut_mem[65], 32'h00001122);
        check("sw102_ref100", ref_mem[64], 32'h3344BABE);

        obs_q.delete();
        do_req(1'b1, 3'b000, 32'h001, 32'h000000AB, mv);
        if (obs_q.size() >= 1) check("sb001_be", 32'(obs_q[0].be), 32'h2);
        check("sb001_mem0", dut_mem[0], 32'hDEADABEF);

        obs_q.delete();
        do_req(1'b0, 3'b011, 32'h100, 32'h0, mv);
        check("ill_nacc", obs_q.size(), 32'd0);
        check("ill_err", 32'(resp_err), 32'h1);
        check("ill_load_data", load_data, 32'h0);
        do_req(1'b0, 3'b010, 32'h000, 32'h0, mv);
        check("after_ill_lw", load_data, 32'hDEADABEF);
        check("after_ill_err", 32'(resp_err), 32'h0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else f3 = f3_tab[$urandom_range(0, 4)];
            if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
            else a = 32'($urandom_range(0, 1023));
            do_req(1'($urandom_range(0, 1)), f3, a, $urandom, mv);
        end

        // Reset during the high half of a wrapping store.
        chk_en = 1'b0;
        w0_before = dut_mem[0];
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'hFFFFFFFE; req_wdata = 32'h55667788;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rmid_lo_we", 32'(mem_we), 32'h1);
        check("rmid_lo_addr", mem_addr, 32'hFFFFFFFC);
        check("rmid_lo_be", 32'(mem_byte_en), 32'hC);
        check("rmid_lo_wdata", mem_wdata, 32'h77880000);
        model_req(1'b1, 3'b010, 32'hFFFFFFFE, 32'h55667788, 1'b0, 1'b1, mv, lat);
        @(posedge clk); #1;
        reset = 1'b0; #1;
        check("rmid_we", 32'(mem_we), 32'h0);
        check("rmid_be", 32'(mem_byte_en), 32'h0);
        check("rmid_addr", mem_addr, 32'h0);
        check("rmid_wdata", mem_wdata, 32'h0);
        check("rmid_ready", 32'(req_ready), 32'h0);
        check("rmid_resp_valid", 32'(resp_valid), 32'h0);
        check("rmid_resp_err", 32'(resp_err), 32'h0);
        check("rmid_load_data", load_data, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rmid_word0_kept", dut_mem[0], w0_before);
        check("rmid_word_top", dut_mem[255], ref_mem[255]);
        @(negedge clk); reset = 1'b1; #1;
        check("rmid_ready_pre", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        check("rmid_ready_post", 32'(req_ready), 32'h1);
        chk_en = 1'b1;
        do_req(1'b0, 3'b010, 32'h000, 32'h0, mv);
        check("rmid_lw0", load_data, w0_before);

        for (int i = 0; i < 256; i++) check("final_mem", dut_mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Pipeline-side initiator for the word-addressed, byte-enabled data memory.
- Accepts one load or store request at a time from the execute stage. It computes byte enables and lane-aligns store data, then issues one word access, or two if the access crosses a word boundary.
- For loads, it extracts, shifts and sign/zero-extends the read data and returns it with a one-cycle response strobe.
- Memory read is combinational. Memory write commits at the posedge while the write-enable is high.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data word width (fixed at 32; 4 byte lanes)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_is_store  in  1  1 = store, 0 = load
req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  illegal funct3; valid with resp_valid
load_data  out  32  extended load result; valid with resp_valid
mem_we  out  1  memory write enable
mem_addr  out  32  word-aligned address, bits [1:0] = 0
mem_wdata  out  32  lane-aligned write data
mem_byte_en  out  4  byte lane enables
mem_rdata  in  32  combinational read data

Behaviour:
- Reset (reset low, async):
  - State goes to IDLE.
  - All outputs are 0: req_ready, resp_valid, resp_err, load_data, mem_we, mem_addr, mem_wdata, mem_byte_en.
  - A pending request is dropped and no memory write is issued.
  - req_ready rises in the first cycle after release.
- FSM states: IDLE, ACC_LO, ACC_HI, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, register is_store, funct3, addr, wdata.
  - Legal funct3 goes to ACC_LO. Illegal funct3 goes to RESP with err = 1.
- ACC_LO:
  - mem_addr = {addr[31:2], 2'b00}.
  - size mask m = 0001 (B), 0011 (H), 1111 (W). off = addr[1:0].
  - 8-bit lane mask L = m << off.
  - mem_byte_en = L[3:0].
  - Store lane data S = {32'b0, wdata} << (8*off) (64-bit); mem_wdata = S[31:0].
  - mem_we = is_store.
  - Loads: capture mem_rdata into buf[31:0].
  - Next state: ACC_HI if L[7:4] != 0, else RESP.
- ACC_HI:
  - mem_addr = {addr[31:2], 2'b00} + 4, modulo 2^32 (0xFFFFFFFC wraps to 0).
  - mem_byte_en = L[7:4]; mem_wdata = S[63:32]; mem_we = is_store.
  - Loads: capture mem_rdata into buf[63:32].
  - Next state: RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle, then IDLE.
  - Load data = (buf >> 8*off)[31:0], then extended:
    - B: sign-extend bit 7. BU: zero-extend bit 7.
    - H: sign-extend bit 15. HU: zero-extend bit 15.
    - W: full 32 bits.
  - Stores and errors: load_data = 0.
- Memory outputs in IDLE and RESP: mem_we = 0, mem_byte_en = 0.
- Memory outputs are decoded from registered state only. No combinational path from req_* to mem_*.
- Latency from the accept edge:
  - Aligned or intra-word access: resp_valid 2 cycles later.
  - Word-crossing access: 3 cycles later.
  - Illegal funct3: 1 cycle later.
- req_ready = 0 outside IDLE. req_valid there is ignored and must be held by the requester.
- Misaligned accesses are legal and are always split, never trapped.
- resp_err and load_data hold their values until the next resp_valid.

Decomposition:
- Shared package: funct3 size/sign encodings, FSM state encoding, lane-mask constants.
- One natural sub-module, lsu_load_extend: combinational shift plus sign/zero extension of the 64-bit buffer by offset and funct3. It is reusable by a future cache path.

Test Plan:
- Preload words 0x000 = DEADBEEF, 0x100 = CAFEBABE, 0x104 = 00000099. LW 0x100 -> single access at 0x100, byte_en 1111; load_data CAFEBABE, resp_err 0, resp_valid 2 cycles after accept.
- LB 0x103 -> FFFFFFCA; LBU 0x103 -> 000000CA; LHU 0x002 -> 0000DEAD.
- LH 0x103 (crossing) -> reads 0x100 byte_en 1000, then 0x104 byte_en 0001; load_data FFFF99CA, resp_valid 3 cycles after accept.
- SW 0x102 data 11223344 -> write 0x100 byte_en 1100 data 33440000, then 0x104 byte_en 0011 data 00001122; memory 0x100 = 3344BABE, 0x104 = 00001122. Then SB 0x001 data AB -> byte_en 0010, memory 0x000 = DEADABEF.
- funct3 011 -> no mem_we, no byte_en; resp_valid with resp_err 1 and load_data 0 one cycle after accept. The next request is accepted normally.
- Crossing SW 0xFFFFFFFE with reset pulled low after ACC_LO -> mem_we drops immediately, no second write (word 0x000 unchanged), all outputs 0, req_ready 1 one cycle after release.
